// File: rtl/kbd_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg
// Shared types and constants for the keyboard scancode receive queue:
//   - kbd_filt_t   : break-sequence filter states
//   - KBD_BREAK    : PS/2 break prefix byte
//   - KBD_EXT      : PS/2 extended-key prefix byte (always enqueued)
//   - KBD_*_OFS    : register offsets from the block base address
//   - KBD_CLR_OVF / KBD_FLUSH : control bit positions in the status register
// ---------------------------------------------------------------------------
package kbd_pkg;

    typedef enum logic {IDLE = 1'b0, SKIP = 1'b1} kbd_filt_t;

    localparam logic [7:0]  KBD_BREAK    = 8'hF0;
    localparam logic [7:0]  KBD_EXT      = 8'hE0;

    localparam logic [31:0] KBD_DATA_OFS = 32'd0;
    localparam logic [31:0] KBD_STAT_OFS = 32'd4;

    localparam int KBD_CLR_OVF = 0;
    localparam int KBD_FLUSH   = 1;

endpackage

// File: rtl/kbd_scancode_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through output.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   push     : write din (accepted when not full, or when full and a pop
//              happens in the same cycle)
//   pop      : drop the head entry (ignored when empty)
//   flush    : empty the FIFO; overrides push and pop
//   din      : write data
//   dout     : head entry (combinational, undefined contents when empty)
//   count    : number of stored entries
//   full     : count == DEPTH
//   empty    : count == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Status flags, qualified push/pop and next pointer/count values.
    always_comb begin
        empty     = (count_q == {(AW + 1){1'b0}});
        full      = (count_q == FULL_CNT);
        // A pop while full frees the slot the simultaneous push needs.
        do_pop_s  = pop & ~empty & ~flush;
        do_push_s = push & ~flush & (~full | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW + 1){1'b0}};
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (AW + 1)'(1'b1);
                2'b01:   count_d = count_q - (AW + 1)'(1'b1);
                default: count_d = count_q;
            endcase
        end
        dout  = mem_q[rd_ptr_q];
        count = count_q;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/kbd_scancode_queue.sv
// ---------------------------------------------------------------------------
// kbd_scancode_queue
// IOBUS receive queue for PS/2 scancodes from the KeyboardDriver.
// Ports:
//   CLK, RST     : bus clock, synchronous active-high reset
//   KB_INTRPT    : asynchronous scancode strobe (synchronised here)
//   KB_SCANCODE  : scancode, stable while KB_INTRPT is high
//   IOBUS_ADDR   : bus address
//   IOBUS_OUT    : CPU write data (only control bits of the status reg used)
//   IOBUS_WR     : CPU write strobe
//   RD_DATA      : combinational read data, 0 outside this block
//   INTR         : one-cycle pulse per scancode written into the queue
// Registers:
//   BASE_AD      : read {23'b0, nonempty, head}; write pops one entry
//   BASE_AD + 4  : read {OVF, 23'b0, count}; write bit0 clears OVF,
//                  bit1 flushes the queue and the break filter
// ---------------------------------------------------------------------------
module kbd_scancode_queue
    import kbd_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] BASE_AD    = 32'h1120_0000,
    parameter bit          DROP_BREAK = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        KB_INTRPT,
    input  logic [7:0]  KB_SCANCODE,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        INTR
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          sync1_q, sync2_q, prev_q;
    logic          edge_q, edge_d;
    logic [7:0]    byte_q, byte_d;
    kbd_filt_t     state_q, state_d;
    logic          ovf_q, ovf_d;
    logic          intr_q, intr_d;

    logic          sel_data_s, sel_stat_s;
    logic          pop_req_s, flush_s, clr_ovf_s;
    logic          accept_s, push_req_s, pop_ok_s, push_ok_s, ovf_set_s;
    logic [7:0]    head_s, count8_s;
    logic [CW-1:0] count_s;
    logic          full_s, empty_s;
    logic          unused_wdata_s;

    assign unused_wdata_s = ^IOBUS_OUT[31:2];

    // Bus decode, break filter, enqueue qualification and next-state logic.
    always_comb begin
        sel_data_s = (IOBUS_ADDR == (BASE_AD + KBD_DATA_OFS));
        sel_stat_s = (IOBUS_ADDR == (BASE_AD + KBD_STAT_OFS));
        pop_req_s  = IOBUS_WR & sel_data_s;
        flush_s    = IOBUS_WR & sel_stat_s & IOBUS_OUT[KBD_FLUSH];
        clr_ovf_s  = IOBUS_WR & sel_stat_s & IOBUS_OUT[KBD_CLR_OVF];

        edge_d = sync2_q & ~prev_q;
        if (edge_d) begin
            byte_d = KB_SCANCODE;
        end else begin
            byte_d = byte_q;
        end

        // Only an idle filter passes bytes; F0 itself is never passed.
        if (!edge_q) begin
            accept_s = 1'b0;
        end else if (!DROP_BREAK) begin
            accept_s = 1'b1;
        end else if (state_q == SKIP) begin
            accept_s = 1'b0;
        end else begin
            accept_s = (byte_q != KBD_BREAK);
        end

        // A flush in the same cycle discards the incoming byte entirely.
        push_req_s = accept_s & ~flush_s;
        pop_ok_s   = pop_req_s & ~empty_s;
        push_ok_s  = push_req_s & (~full_s | pop_ok_s);
        ovf_set_s  = push_req_s & full_s & ~pop_ok_s;

        state_d = state_q;
        if (flush_s) begin
            state_d = IDLE;
        end else if (edge_q && DROP_BREAK) begin
            case (state_q)
                IDLE: begin
                    if (byte_q == KBD_BREAK) begin
                        state_d = SKIP;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SKIP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        // Set beats clear when both happen in one cycle.
        ovf_d  = ovf_set_s | (ovf_q & ~clr_ovf_s);
        intr_d = push_ok_s;
    end

    // Synchroniser, edge detector, captured byte, filter, OVF and INTR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
            byte_q  <= 8'h00;
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            sync1_q <= KB_INTRPT;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= edge_d;
            byte_q  <= byte_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            intr_q  <= intr_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push_req_s),
        .pop   (pop_req_s),
        .flush (flush_s),
        .din   (byte_q),
        .dout  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Combinational read mux so a load completes in the existing bus cycle.
    always_comb begin
        count8_s = 8'(count_s);
        if (sel_data_s) begin
            if (empty_s) begin
                RD_DATA = 32'h0000_0000;
            end else begin
                RD_DATA = {23'd0, 1'b1, head_s};
            end
        end else if (sel_stat_s) begin
            RD_DATA = {ovf_q, 23'd0, count8_s};
        end else begin
            RD_DATA = 32'h0000_0000;
        end
        INTR = intr_q;
    end

endmodule

// File: tb/tb_kbd_scancode_queue.sv
module tb_kbd_scancode_queue;

    localparam logic [31:0] BASE = 32'h1120_0000;
    localparam logic [31:0] STAT = 32'h1120_0004;

    typedef struct packed {
        logic [7:0] code;
        logic       exp_intr;
        logic [7:0] exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        kb_intrpt;
    logic [7:0]  kb_code;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rd, rd_nb;
    logic        intr, intr_nb;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q [$];
    logic        model_ovf;

    always #5 clk = ~clk;

    kbd_scancode_queue #(.DEPTH(16), .BASE_AD(BASE), .DROP_BREAK(1'b1)) u_dut (
        .CLK(clk), .RST(rst), .KB_INTRPT(kb_intrpt), .KB_SCANCODE(kb_code),
        .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
        .RD_DATA(rd), .INTR(intr)
    );

    kbd_scancode_queue #(.DEPTH(16), .BASE_AD(BASE), .DROP_BREAK(1'b0)) u_dut_nb (
        .CLK(clk), .RST(rst), .KB_INTRPT(kb_intrpt), .KB_SCANCODE(kb_code),
        .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
        .RD_DATA(rd_nb), .INTR(intr_nb)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd;
    endtask

    task automatic rd_reg_nb(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd_nb;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
        wdata = 32'd0;
    endtask

    // Strobe high for 3 cycles, low for 5; count INTR pulses in the window.
    task automatic send_key(input logic [7:0] c, output int pulses, output int first);
        kb_code   = c;
        kb_intrpt = 1'b1;
        pulses    = 0;
        first     = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (intr) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == 3) kb_intrpt = 1'b0;
        end
    endtask

    // Send a key and update the scoreboard; filt_ok = byte passes the filter.
    task automatic key_model(input logic [7:0] c, input logic filt_ok, input string name);
        int   p, f;
        logic exp_push;
        exp_push = filt_ok && (exp_q.size() < 16);
        send_key(c, p, f);
        check(name, p, exp_push ? 32'd1 : 32'd0);
        if (exp_push) exp_q.push_back(c);
        else if (filt_ok) model_ovf = 1'b1;
    endtask

    // Read the head, compare against the scoreboard, then pop both.
    task automatic pop_check(input string name);
        logic [31:0] d;
        logic [31:0] e;
        rd_reg(BASE, d);
        if (exp_q.size() == 0) e = 32'd0;
        else e = {23'd0, 1'b1, exp_q[0]};
        check(name, d, e);
        wr_reg(BASE, 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    function automatic logic [31:0] exp_stat();
        logic [7:0] c;
        c = 8'(exp_q.size());
        return {model_ovf, 23'd0, c};
    endfunction

    initial begin
        vec_t        vecs [5];
        logic [31:0] d;
        int          p, f;

        vecs[0] = '{code: 8'h1C, exp_intr: 1'b1, exp_cnt: 8'd1};
        vecs[1] = '{code: 8'hF0, exp_intr: 1'b0, exp_cnt: 8'd1};
        vecs[2] = '{code: 8'h1C, exp_intr: 1'b0, exp_cnt: 8'd1};
        vecs[3] = '{code: 8'hE0, exp_intr: 1'b1, exp_cnt: 8'd2};
        vecs[4] = '{code: 8'h75, exp_intr: 1'b1, exp_cnt: 8'd3};

        rst       = 1'b1;
        kb_intrpt = 1'b1;
        kb_code   = 8'h55;
        addr      = STAT;
        wdata     = 32'd0;
        wr        = 1'b0;
        model_ovf = 1'b0;

        // Reset, with a strobe that is only high while reset is asserted.
        repeat (3) @(negedge clk);
        kb_intrpt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (intr) p++;
        end
        check("reset_no_intr", p, 32'd0);
        rd_reg(STAT, d);
        check("reset_stat", d, 32'd0);
        rd_reg(BASE, d);
        check("reset_data", d, 32'd0);

        // Single key: one INTR four cycles after the strobe, then pop.
        send_key(8'h1C, p, f);
        check("single_pulses", p, 32'd1);
        check("single_latency", f, 32'd4);
        exp_q.push_back(8'h1C);
        rd_reg(BASE, d);
        check("single_head", d, 32'h0000_011C);
        pop_check("single_pop");
        rd_reg(BASE, d);
        check("single_empty", d, 32'd0);
        rd_reg(STAT, d);
        check("single_stat", d, 32'd0);

        // Break filtering, table driven.
        for (int i = 0; i < 5; i++) begin
            send_key(vecs[i].code, p, f);
            check($sformatf("brk_intr[%0d]", i), p, {31'd0, vecs[i].exp_intr});
            if (vecs[i].exp_intr) exp_q.push_back(vecs[i].code);
            rd_reg(STAT, d);
            check($sformatf("brk_cnt[%0d]", i), d, {24'd0, vecs[i].exp_cnt});
        end
        rd_reg_nb(STAT, d);
        check("nobrk_cnt", d, 32'd5);
        rd_reg_nb(BASE, d);
        check("nobrk_head", d, 32'h0000_011C);
        for (int i = 0; i < 3; i++) pop_check($sformatf("brk_pop[%0d]", i));
        wr_reg(STAT, 32'd2);
        rd_reg(STAT, d);
        check("brk_flush", d, 32'd0);
        rd_reg_nb(STAT, d);
        check("nobrk_flush", d, 32'd0);

        // Overflow: 17 codes into 16 entries.
        for (int i = 0; i < 17; i++) key_model(8'h30 + 8'(i), 1'b1, $sformatf("ovf_intr[%0d]", i));
        rd_reg(STAT, d);
        check("ovf_stat", d, exp_stat());
        check("ovf_stat_lit", d, 32'h8000_0010);
        wr_reg(STAT, 32'd1);
        model_ovf = 1'b0;
        rd_reg(STAT, d);
        check("ovf_clear", d, 32'h0000_0010);

        // Full FIFO: pop in the same cycle as the enqueue edge.
        kb_code   = 8'h5A;
        kb_intrpt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        kb_intrpt = 1'b0;
        addr      = BASE;
        wr        = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("fullpp_intr", intr, 32'd1);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h5A);
        rd_reg(STAT, d);
        check("fullpp_stat", d, exp_stat());
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) pop_check($sformatf("fullpp_drain[%0d]", i));
        rd_reg(STAT, d);
        check("fullpp_empty", d, 32'd0);

        // Wrap-around: 40 codes, two pushes then two pops.
        for (int i = 0; i < 40; i++) begin
            key_model(8'h80 + 8'(i), 1'b1, $sformatf("wrap_intr[%0d]", i));
            rd_reg(STAT, d);
            check($sformatf("wrap_cnt[%0d]", i), d, exp_stat());
            if (i % 2 == 1) begin
                pop_check($sformatf("wrap_popa[%0d]", i));
                pop_check($sformatf("wrap_popb[%0d]", i));
            end
        end

        // Flush after F0 returns the filter to IDLE.
        key_model(8'hF0, 1'b0, "flush_f0");
        wr_reg(STAT, 32'd2);
        exp_q.delete();
        key_model(8'h2A, 1'b1, "flush_2a");
        rd_reg(BASE, d);
        check("flush_head", d, 32'h0000_012A);
        for (int i = 0; i < 4; i++) key_model(8'h41 + 8'(i), 1'b1, $sformatf("rst_fill[%0d]", i));
        rd_reg(STAT, d);
        check("rst_pre_cnt", d, 32'd5);

        // Reset with five entries queued.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("rst_intr", intr, 32'd0);
        rd_reg(STAT, d);
        check("rst_stat", d, 32'd0);
        rd_reg(BASE, d);
        check("rst_data", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kbd_scancode_queue.md
# kbd_scancode_queue

Memory-mapped receive queue between the PS/2 `KeyboardDriver` and the OTTER IOBUS read mux. It synchronises and edge-detects the driver's scancode strobe and can optionally drop PS/2 break sequences. Accepted scancodes are buffered in a FIFO, so bursts of keystrokes are not lost while the CPU is busy. Each accepted scancode raises a one-cycle interrupt pulse. The CPU reads the head and status over IOBUS and pops or flushes the queue with IOBUS writes.

## Interface
- `DEPTH`, 16 — FIFO entries; power of two, 2..128.
- `BASE_AD`, 32'h11200000 — data/pop register address; status/control register at `BASE_AD+4`.
- `DROP_BREAK`, 1 — 1: the F0 byte and the byte following it are never enqueued; 0: every byte is enqueued.
- `CLK`  in  1  bus clock (50 MHz `sclk`); single clock domain.
- `RST`  in  1  synchronous, active-high reset.
- `KB_INTRPT`  in  1  scancode strobe from `KeyboardDriver`.
  - Treated as asynchronous.
  - Must stay high for ≥2 `CLK` cycles and low for ≥2 `CLK` cycles between strobes.
- `KB_SCANCODE`  in  8  scancode; stable while `KB_INTRPT` is high.
- `IOBUS_ADDR`  in  32  bus address.
- `IOBUS_OUT`  in  32  CPU write data.
- `IOBUS_WR`  in  1  CPU write strobe.
- `RD_DATA`  out  32  combinational read data; 0 when `IOBUS_ADDR` is neither register.
- `INTR`  out  1  one-cycle pulse per accepted scancode; ORed into MCU `INTR` in the top level.

## Operation
- **Input path:** 2-flop synchroniser on `KB_INTRPT`, then a rising-edge detector. On a detected edge, `KB_SCANCODE` is registered and presented to the filter in the same cycle.
- **Filter FSM, states IDLE and SKIP** (only when `DROP_BREAK`=1):
  - IDLE, byte = 8'hF0: discard the byte, go to SKIP.
  - IDLE, any other byte (including 8'hE0): enqueue it.
  - SKIP, any byte: discard it, go to IDLE.
  - With `DROP_BREAK`=0 the FSM stays in IDLE and every byte is enqueued.
- **Enqueue:**
  - FIFO not full: write the byte and pulse `INTR`.
  - FIFO full and no pop in the same cycle: drop the byte, set sticky `OVF`, no `INTR`.
- **Read at `BASE_AD`:** `{23'b0, nonempty, head[7:0]}`. `head` reads 0 when the FIFO is empty.
- **Read at `BASE_AD+4`:** `{OVF, 23'b0, count[7:0]}`, with `count` zero-extended.
- **Write to `BASE_AD`:** pop one entry; ignored when empty. Write data is ignored.
- **Write to `BASE_AD+4`:**
  - bit0 = 1 clears `OVF`.
  - bit1 = 1 flushes: `count` goes to 0, pointers reset, FSM goes to IDLE.
- **Simultaneous events:**
  - Push and pop while full: both succeed, `count` unchanged, no `OVF`, `INTR` pulses.
  - Push and pop while empty: the pop is ignored, the push succeeds, `count` = 1.
  - Flush concurrent with a push: flush wins, the byte is discarded, no `INTR`.
  - `OVF` clear concurrent with an overflow event: set wins, `OVF` = 1.
- **Wrap-around:** read/write pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` is `$clog2(DEPTH)+1` bits.

## Timing
- **Reset (synchronous):** `INTR` = 0, `count` = 0, `OVF` = 0, FSM = IDLE, synchroniser and edge flops = 0. A strobe that is high during reset produces no edge.
- **Strobe latency:** `KB_INTRPT` rising before CLK edge k leads to the edge being detected in cycle k+2 and the byte written at edge k+3. `INTR` is high for the cycle after edge k+3, and `RD_DATA`/`count` update in that same cycle.
- **Pop/flush/clear:** sampled at the CLK edge where `IOBUS_WR` = 1. Effects are visible in `RD_DATA` from the next cycle.
- **Read path:** `RD_DATA` is purely combinational from `IOBUS_ADDR` and state, so a load completes in the MCU's existing read cycle.
- **Throughput:** one enqueue and one pop per cycle maximum.

## Structure
- Package `kbd_pkg`:
  - `typedef enum logic {IDLE, SKIP} kbd_filt_t;`
  - `KBD_BREAK` = 8'hF0, `KBD_EXT` = 8'hE0
  - offsets `KBD_DATA_OFS` = 0, `KBD_STAT_OFS` = 4
  - control bit indices `KBD_CLR_OVF` = 0, `KBD_FLUSH` = 1
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`; ports `push`, `pop`, `flush`, `din`, `dout`, `count`, `full`, `empty`). It holds storage, pointers and count.
- The top module holds the synchroniser, edge detect, filter FSM, `OVF`, `INTR` and the bus decode.

## Test plan
- **Reset and single key:** after reset, read `BASE+4` returns 0. A strobe with 8'h1C leads to one `INTR` pulse 4 cycles later; read `BASE` = 32'h0000_011C; pop, then read `BASE` = 0.
- **Break filtering** (`DROP_BREAK`=1): send 1C, F0, 1C, E0, 75; queue holds 1C, E0, 75 and `INTR` pulses 3 times. With `DROP_BREAK`=0 the queue holds all 5 bytes.
- **Overflow:** send 17 distinct codes with `DEPTH`=16; `count` = 16, `OVF` = 1, the 17th code is absent and there is no 17th `INTR`. Write 1 to `BASE+4`: `OVF` = 0.
- **Full push + pop:** with the FIFO full, pop in the same cycle as the enqueue edge; `count` stays 16, the new byte is at the tail, `OVF` = 0.
- **Wrap-around:** push and pop 40 codes interleaved; every pop returns the codes in order, and `count` never exceeds 2.
- **Flush/reset mid-operation:** after F0 is received, flush; the next byte 8'h2A is enqueued because the FSM is back in IDLE. `RST` asserted with 5 queued entries: `count` = 0 and `INTR` = 0 next cycle.
